// File: rtl/reorder_buffer_param.sv
// rtl/reorder_buffer_param.sv - in-order-commit reorder buffer; ROB_PERF_CNT_EN adds commit/flush perf counters
module reorder_buffer_param #(
    parameter int DEPTH   = 32,
    parameter int IDX_W   = 5,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       disp_valid_in,
    input  logic [6:0]                 disp_type_in,
    input  logic [XLEN-1:0]            disp_pc_in,
    input  logic [4:0]                 disp_rd_in,
    input  logic [XLEN-1:0]            disp_value_in,
    input  logic [XLEN-1:0]            disp_imm_in,
    input  logic                       disp_rvc_in,
    output logic                       full_out,
    output logic [IDX_W-1:0]           tail_id_out,
    output logic                       rf_launch_valid_out,
    output logic [IDX_W-1:0]           rf_launch_id_out,
    output logic [4:0]                 rf_launch_rd_out,
    input  logic [2*IDX_W-1:0]         src_tag_in,
    input  logic [2*XLEN-1:0]          src_rf_val_in,
    output logic [2*IDX_W-1:0]         src_dep_out,
    output logic [2*XLEN-1:0]          src_val_out,
    input  logic [NUM_CDB-1:0]         cdb_valid_in,
    input  logic [NUM_CDB*IDX_W-1:0]   cdb_id_in,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_value_in,
    output logic [NUM_CDB-1:0]         bc_valid_out,
    output logic [NUM_CDB*IDX_W-1:0]   bc_id_out,
    output logic [NUM_CDB*XLEN-1:0]    bc_value_out,
    output logic                       cm_valid_out,
    output logic [IDX_W-1:0]           cm_id_out,
    output logic [4:0]                 cm_rd_out,
    output logic [XLEN-1:0]            cm_value_out,
    output logic                       flush_out,
    output logic                       stall_out,
    output logic                       redirect_valid_out,
    output logic [XLEN-1:0]            redirect_pc_out,
    output logic                       store_ready_out
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                perf_commit_cnt_out,
    output logic [31:0]                perf_flush_cnt_out
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    function automatic logic writes_rd(input logic [6:0] t);
        return (t == OPC_OP) || (t == OPC_OP_IMM) || (t == OPC_LOAD) || (t == OPC_JAL) ||
               (t == OPC_JALR) || (t == OPC_AUIPC) || (t == OPC_LUI);
    endfunction

    // Tag 0 means "no dependency", so pointers skip it on wrap.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == IDX_LAST) ? IDX_ONE : p + IDX_ONE;
    endfunction

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] done_q;
    logic [6:0]       type_q   [DEPTH];
    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [XLEN-1:0]  value_q  [DEPTH];
    logic [XLEN-1:0]  imm_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic             rvc_q    [DEPTH];

    logic [IDX_W-1:0] head_q, tail_q, count_q;
    logic             head_announced_q;

    logic             commit, disp_accept, head_is_branch, head_is_jalr;
    logic [6:0]       head_type;
    logic [XLEN-1:0]  seq_pc;
    logic [IDX_W-1:0] src_tag, cdb_id;
    logic             cdb_hit;
    logic [XLEN-1:0]  cdb_val;

    // Head decode, commit/redirect, dispatch acceptance and rename launch.
    always_comb begin
        head_type           = type_q[head_q];
        head_is_branch      = (head_type == OPC_BRANCH);
        head_is_jalr        = (head_type == OPC_JALR);
        full_out            = (count_q == IDX_LAST);
        tail_id_out         = tail_q;
        commit              = rdy_in & busy_q[head_q] & done_q[head_q];
        flush_out           = commit & head_is_branch & (rd_q[head_q][0] != value_q[head_q][0]);
        stall_out           = commit & head_is_jalr;
        redirect_valid_out  = flush_out | stall_out;
        seq_pc              = rvc_q[head_q] ? pc_q[head_q] + XLEN'(2) : pc_q[head_q] + XLEN'(4);
        if (head_is_jalr)
            redirect_pc_out = {target_q[head_q][XLEN-1:1], 1'b0};
        else if (value_q[head_q][0])
            redirect_pc_out = pc_q[head_q] + imm_q[head_q];
        else
            redirect_pc_out = seq_pc;
        cm_valid_out        = commit & writes_rd(head_type);
        cm_id_out           = head_q;
        cm_rd_out           = rd_q[head_q];
        cm_value_out        = value_q[head_q];
        store_ready_out     = busy_q[head_q] & ((head_type == OPC_LOAD) || (head_type == OPC_STORE)) &
                              ~head_announced_q;
        disp_accept         = rdy_in & disp_valid_in & ~full_out & ~flush_out;
        rf_launch_valid_out = disp_accept & writes_rd(disp_type_in);
        rf_launch_id_out    = tail_q;
        rf_launch_rd_out    = disp_rd_in;
    end

    // Operand resolution: same-cycle CDB beats stored result; highest port wins.
    always_comb begin
        src_dep_out = '0;
        src_val_out = '0;
        src_tag     = '0;
        cdb_id      = '0;
        cdb_hit     = 1'b0;
        cdb_val     = '0;
        for (int s = 0; s < 2; s++) begin
            src_tag = src_tag_in[s*IDX_W +: IDX_W];
            cdb_hit = 1'b0;
            cdb_val = '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_id = cdb_id_in[k*IDX_W +: IDX_W];
                if (cdb_valid_in[k] && (cdb_id == src_tag)) begin
                    cdb_hit = 1'b1;
                    cdb_val = cdb_value_in[k*XLEN +: XLEN];
                end
            end
            if (src_tag == '0) begin
                src_val_out[s*XLEN +: XLEN] = src_rf_val_in[s*XLEN +: XLEN];
            end else if (cdb_hit) begin
                src_val_out[s*XLEN +: XLEN] = cdb_val;
            end else if (done_q[src_tag]) begin
                src_val_out[s*XLEN +: XLEN] = value_q[src_tag];
            end else begin
                src_dep_out[s*IDX_W +: IDX_W] = src_tag;
            end
        end
    end

    // Control state: pointers, occupancy, busy/done flags and CDB re-broadcast.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q           <= '0;
            done_q           <= '0;
            head_q           <= IDX_ONE;
            tail_q           <= IDX_ONE;
            count_q          <= '0;
            head_announced_q <= 1'b0;
            bc_valid_out     <= '0;
            bc_id_out        <= '0;
            bc_value_out     <= '0;
        end else if (rdy_in) begin
            bc_valid_out <= cdb_valid_in;
            bc_id_out    <= cdb_id_in;
            bc_value_out <= cdb_value_in;
            if (flush_out) begin
                busy_q           <= '0;
                done_q           <= '0;
                head_q           <= IDX_ONE;
                tail_q           <= IDX_ONE;
                count_q          <= '0;
                head_announced_q <= 1'b0;
            end else begin
                if (commit) begin
                    busy_q[head_q]   <= 1'b0;
                    head_q           <= next_idx(head_q);
                    head_announced_q <= 1'b0;
                end else if (store_ready_out) begin
                    head_announced_q <= 1'b1;
                end
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cdb_valid_in[k] && busy_q[cdb_id_in[k*IDX_W +: IDX_W]])
                        done_q[cdb_id_in[k*IDX_W +: IDX_W]] <= 1'b1;
                end
                if (disp_accept) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= (disp_type_in == OPC_LUI);
                    tail_q         <= next_idx(tail_q);
                end
                if (disp_accept && !commit)
                    count_q <= count_q + IDX_ONE;
                else if (!disp_accept && commit)
                    count_q <= count_q - IDX_ONE;
            end
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_out) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid_in[k] && busy_q[cdb_id_in[k*IDX_W +: IDX_W]]) begin
                    if (type_q[cdb_id_in[k*IDX_W +: IDX_W]] == OPC_JALR)
                        target_q[cdb_id_in[k*IDX_W +: IDX_W]] <= cdb_value_in[k*XLEN +: XLEN];
                    else
                        value_q[cdb_id_in[k*IDX_W +: IDX_W]] <= cdb_value_in[k*XLEN +: XLEN];
                end
            end
            if (disp_accept) begin
                type_q[tail_q]  <= disp_type_in;
                pc_q[tail_q]    <= disp_pc_in;
                rd_q[tail_q]    <= disp_rd_in;
                value_q[tail_q] <= disp_value_in;
                imm_q[tail_q]   <= disp_imm_in;
                rvc_q[tail_q]   <= disp_rvc_in;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Free-running commit and flush counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_commit_cnt_out <= '0;
            perf_flush_cnt_out  <= '0;
        end else begin
            if (commit)
                perf_commit_cnt_out <= perf_commit_cnt_out + 32'd1;
            if (flush_out)
                perf_flush_cnt_out <= perf_flush_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer_param.sv
// tb/tb_reorder_buffer_param.sv - self-checking bench for reorder_buffer_param
module tb_reorder_buffer_param;

    localparam int DEPTH   = 32;
    localparam int IDX_W   = 5;
    localparam int XLEN    = 32;
    localparam int NUM_CDB = 2;

    localparam logic [6:0] T_ADDI   = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     rdy_in;
    logic                     disp_valid_in;
    logic [6:0]               disp_type_in;
    logic [XLEN-1:0]          disp_pc_in;
    logic [4:0]               disp_rd_in;
    logic [XLEN-1:0]          disp_value_in;
    logic [XLEN-1:0]          disp_imm_in;
    logic                     disp_rvc_in;
    logic                     full_out;
    logic [IDX_W-1:0]         tail_id_out;
    logic                     rf_launch_valid_out;
    logic [IDX_W-1:0]         rf_launch_id_out;
    logic [4:0]               rf_launch_rd_out;
    logic [2*IDX_W-1:0]       src_tag_in;
    logic [2*XLEN-1:0]        src_rf_val_in;
    logic [2*IDX_W-1:0]       src_dep_out;
    logic [2*XLEN-1:0]        src_val_out;
    logic [NUM_CDB-1:0]       cdb_valid_in;
    logic [NUM_CDB*IDX_W-1:0] cdb_id_in;
    logic [NUM_CDB*XLEN-1:0]  cdb_value_in;
    logic [NUM_CDB-1:0]       bc_valid_out;
    logic [NUM_CDB*IDX_W-1:0] bc_id_out;
    logic [NUM_CDB*XLEN-1:0]  bc_value_out;
    logic                     cm_valid_out;
    logic [IDX_W-1:0]         cm_id_out;
    logic [4:0]               cm_rd_out;
    logic [XLEN-1:0]          cm_value_out;
    logic                     flush_out;
    logic                     stall_out;
    logic                     redirect_valid_out;
    logic [XLEN-1:0]          redirect_pc_out;
    logic                     store_ready_out;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]              perf_commit_cnt_out;
    logic [31:0]              perf_flush_cnt_out;
`endif

    always #5 clk_in = ~clk_in;

    reorder_buffer_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .disp_valid_in(disp_valid_in), .disp_type_in(disp_type_in), .disp_pc_in(disp_pc_in),
        .disp_rd_in(disp_rd_in), .disp_value_in(disp_value_in), .disp_imm_in(disp_imm_in),
        .disp_rvc_in(disp_rvc_in), .full_out(full_out), .tail_id_out(tail_id_out),
        .rf_launch_valid_out(rf_launch_valid_out), .rf_launch_id_out(rf_launch_id_out),
        .rf_launch_rd_out(rf_launch_rd_out), .src_tag_in(src_tag_in), .src_rf_val_in(src_rf_val_in),
        .src_dep_out(src_dep_out), .src_val_out(src_val_out), .cdb_valid_in(cdb_valid_in),
        .cdb_id_in(cdb_id_in), .cdb_value_in(cdb_value_in), .bc_valid_out(bc_valid_out),
        .bc_id_out(bc_id_out), .bc_value_out(bc_value_out), .cm_valid_out(cm_valid_out),
        .cm_id_out(cm_id_out), .cm_rd_out(cm_rd_out), .cm_value_out(cm_value_out),
        .flush_out(flush_out), .stall_out(stall_out), .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out), .store_ready_out(store_ready_out)
`ifdef ROB_PERF_CNT_EN
        , .perf_commit_cnt_out(perf_commit_cnt_out), .perf_flush_cnt_out(perf_flush_cnt_out)
`endif
    );

    typedef struct {
        logic [IDX_W-1:0] id;
        logic [4:0]       rd;
        logic [XLEN-1:0]  value;
    } cm_t;

    cm_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic idle_inputs();
        rdy_in        = 1'b1;
        disp_valid_in = 1'b0;
        disp_type_in  = '0;
        disp_pc_in    = '0;
        disp_rd_in    = '0;
        disp_value_in = '0;
        disp_imm_in   = '0;
        disp_rvc_in   = 1'b0;
        src_tag_in    = '0;
        src_rf_val_in = '0;
        cdb_valid_in  = '0;
        cdb_id_in     = '0;
        cdb_value_in  = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        idle_inputs();
        exp_q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic set_disp(input logic [6:0] t, input logic [XLEN-1:0] pc, input logic [4:0] rd,
                            input logic [XLEN-1:0] val, input logic [XLEN-1:0] imm, input logic rvc);
        disp_valid_in = 1'b1;
        disp_type_in  = t;
        disp_pc_in    = pc;
        disp_rd_in    = rd;
        disp_value_in = val;
        disp_imm_in   = imm;
        disp_rvc_in   = rvc;
    endtask

    task automatic disp(input logic [6:0] t, input logic [XLEN-1:0] pc, input logic [4:0] rd,
                        input logic [XLEN-1:0] val, input logic [XLEN-1:0] imm, input logic rvc);
        set_disp(t, pc, rd, val, imm, rvc);
        step();
        disp_valid_in = 1'b0;
    endtask

    task automatic cdb0(input logic [IDX_W-1:0] id, input logic [XLEN-1:0] val);
        cdb_valid_in          = 2'b01;
        cdb_id_in[IDX_W-1:0]  = id;
        cdb_value_in[XLEN-1:0] = val;
        step();
        cdb_valid_in = '0;
    endtask

    task automatic test_reset();
        disp(T_ADDI, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0);
        disp(T_ADDI, 32'h4, 5'd2, 32'h0, 32'h0, 1'b0);
        cdb0(5'd1, 32'h55);
        rst_n_in = 1'b0;
        #1;
        checks++; if (dut.count_q !== 5'd0) begin errors++; $display("FAIL reset_count: got %0h want 0", dut.count_q); end
        checks++; if (tail_id_out !== 5'd1) begin errors++; $display("FAIL reset_tail: got %0h want 1", tail_id_out); end
        checks++; if (bc_valid_out !== 2'b00) begin errors++; $display("FAIL reset_bc_valid: got %0h want 0", bc_valid_out); end
        checks++; if (cm_valid_out !== 1'b0 || full_out !== 1'b0 || store_ready_out !== 1'b0 || redirect_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got cm=%0b full=%0b sr=%0b rv=%0b want all 0", cm_valid_out, full_out, store_ready_out, redirect_valid_out);
        end
        do_reset();
    endtask

    task automatic test_in_order();
        logic [IDX_W-1:0] ids [3];
        cm_t e;
        ids[0] = 5'd3; ids[1] = 5'd1; ids[2] = 5'd2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (tail_id_out !== IDX_W'(i + 1)) begin errors++; $display("FAIL order_tail: got %0h want %0h", tail_id_out, i + 1); end
            exp_q.push_back('{id: IDX_W'(i + 1), rd: 5'(i + 1), value: XLEN'(32'hA0 + i + 1)});
            set_disp(T_ADDI, XLEN'(4 * i), 5'(i + 1), 32'h0, 32'h0, 1'b0);
            if (i == 0) begin
                @(negedge clk_in);
                checks++; if (rf_launch_valid_out !== 1'b1 || rf_launch_id_out !== 5'd1 || rf_launch_rd_out !== 5'd1) begin
                    errors++; $display("FAIL order_launch: got v=%0b id=%0h rd=%0h want 1/1/1", rf_launch_valid_out, rf_launch_id_out, rf_launch_rd_out);
                end
            end
            step();
            disp_valid_in = 1'b0;
        end
        checks++; if (dut.count_q !== 5'd3) begin errors++; $display("FAIL order_count3: got %0h want 3", dut.count_q); end
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                cdb_valid_in           = 2'b01;
                cdb_id_in[IDX_W-1:0]   = ids[c];
                cdb_value_in[XLEN-1:0] = XLEN'(32'hA0) + XLEN'(ids[c]);
            end else begin
                cdb_valid_in = '0;
            end
            @(negedge clk_in);
            if (c == 1) begin
                checks++; if (bc_valid_out[0] !== 1'b1 || bc_id_out[IDX_W-1:0] !== 5'd3 || bc_value_out[XLEN-1:0] !== 32'hA3) begin
                    errors++; $display("FAIL order_bcast: got v=%0b id=%0h val=%0h want 1/3/a3", bc_valid_out[0], bc_id_out[IDX_W-1:0], bc_value_out[XLEN-1:0]);
                end
            end
            if (cm_valid_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL order_extra_commit: got id %0h want none", cm_id_out);
                end else begin
                    e = exp_q.pop_front();
                    if (cm_id_out !== e.id || cm_rd_out !== e.rd || cm_value_out !== e.value) begin
                        errors++; $display("FAIL order_commit: got id=%0h rd=%0h val=%0h want id=%0h rd=%0h val=%0h",
                                           cm_id_out, cm_rd_out, cm_value_out, e.id, e.rd, e.value);
                    end
                end
            end
            @(posedge clk_in);
            #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL order_missing_commits: got %0d left want 0", exp_q.size()); end
        checks++; if (dut.count_q !== 5'd0) begin errors++; $display("FAIL order_count0: got %0h want 0", dut.count_q); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) disp(T_ADDI, XLEN'(4 * i), 5'd1, 32'h0, 32'h0, 1'b0);
        checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b want 1", full_out); end
        checks++; if (tail_id_out !== 5'd1) begin errors++; $display("FAIL full_tail_wrap: got %0h want 1", tail_id_out); end
        set_disp(T_ADDI, 32'h400, 5'd2, 32'h0, 32'h0, 1'b0);
        @(negedge clk_in);
        checks++; if (rf_launch_valid_out !== 1'b0) begin errors++; $display("FAIL full_launch: got %0b want 0", rf_launch_valid_out); end
        step();
        disp_valid_in = 1'b0;
        checks++; if (tail_id_out !== 5'd1 || dut.count_q !== 5'd31) begin
            errors++; $display("FAIL full_ignored: got tail=%0h count=%0h want 1/1f", tail_id_out, dut.count_q);
        end
    endtask

    task automatic test_store_ready();
        do_reset();
        disp(T_LOAD, 32'h40, 5'd3, 32'h0, 32'h0, 1'b0);
        @(negedge clk_in);
        checks++; if (store_ready_out !== 1'b1) begin errors++; $display("FAIL store_ready_first: got %0b want 1", store_ready_out); end
        step();
        @(negedge clk_in);
        checks++; if (store_ready_out !== 1'b0) begin errors++; $display("FAIL store_ready_once: got %0b want 0", store_ready_out); end
        step();
    endtask

    task automatic test_branch();
        do_reset();
        disp(T_BRANCH, 32'h100, 5'd0, 32'h0, 32'h20, 1'b0);
        disp(T_ADDI, 32'h104, 5'd4, 32'h0, 32'h0, 1'b0);
        cdb0(5'd1, 32'h1);
        set_disp(T_ADDI, 32'h108, 5'd5, 32'h0, 32'h0, 1'b0);
        @(negedge clk_in);
        checks++; if (flush_out !== 1'b1 || redirect_valid_out !== 1'b1 || cm_valid_out !== 1'b0) begin
            errors++; $display("FAIL br_flush: got fl=%0b rv=%0b cm=%0b want 1/1/0", flush_out, redirect_valid_out, cm_valid_out);
        end
        checks++; if (redirect_pc_out !== 32'h120) begin errors++; $display("FAIL br_taken_pc: got %0h want 120", redirect_pc_out); end
        step();
        disp_valid_in = 1'b0;
        checks++; if (dut.count_q !== 5'd0 || tail_id_out !== 5'd1) begin
            errors++; $display("FAIL br_after_flush: got count=%0h tail=%0h want 0/1", dut.count_q, tail_id_out);
        end
        disp(T_BRANCH, 32'h200, 5'd1, 32'h0, 32'h40, 1'b1);
        cdb0(5'd1, 32'h0);
        @(negedge clk_in);
        checks++; if (flush_out !== 1'b1 || redirect_pc_out !== 32'h202) begin
            errors++; $display("FAIL br_rvc_not_taken: got fl=%0b pc=%0h want 1/202", flush_out, redirect_pc_out);
        end
        step();
        disp(T_BRANCH, 32'h10, 5'd1, 32'h0, 32'hFFFF_FFF8, 1'b0);
        cdb0(5'd1, 32'h1);
        @(negedge clk_in);
        checks++; if (flush_out !== 1'b0 || redirect_valid_out !== 1'b0 || redirect_pc_out !== 32'h8) begin
            errors++; $display("FAIL br_predicted_ok: got fl=%0b rv=%0b pc=%0h want 0/0/8", flush_out, redirect_valid_out, redirect_pc_out);
        end
        step();
        checks++; if (dut.count_q !== 5'd0) begin errors++; $display("FAIL br_commit_count: got %0h want 0", dut.count_q); end
    endtask

    task automatic test_jalr();
        cm_t e;
        do_reset();
        exp_q.push_back('{id: 5'd1, rd: 5'd5, value: 32'h304});
        disp(T_JALR, 32'h300, 5'd5, 32'h304, 32'h0, 1'b0);
        cdb0(5'd1, 32'h2001);
        @(negedge clk_in);
        checks++; if (stall_out !== 1'b1 || redirect_valid_out !== 1'b1 || flush_out !== 1'b0 || redirect_pc_out !== 32'h2000) begin
            errors++; $display("FAIL jalr_redirect: got st=%0b rv=%0b fl=%0b pc=%0h want 1/1/0/2000", stall_out, redirect_valid_out, flush_out, redirect_pc_out);
        end
        checks++;
        if (!cm_valid_out || exp_q.size() == 0) begin
            errors++; $display("FAIL jalr_commit: got cm_valid=%0b want 1", cm_valid_out);
        end else begin
            e = exp_q.pop_front();
            if (cm_id_out !== e.id || cm_rd_out !== e.rd || cm_value_out !== e.value) begin
                errors++; $display("FAIL jalr_link: got id=%0h rd=%0h val=%0h want id=%0h rd=%0h val=%0h", cm_id_out, cm_rd_out, cm_value_out, e.id, e.rd, e.value);
            end
        end
        step();
    endtask

    task automatic test_src_lookup();
        do_reset();
        for (int i = 0; i < 5; i++) disp(T_ADDI, XLEN'(4 * i), 5'(i + 1), 32'h0, 32'h0, 1'b0);
        src_tag_in    = {5'd4, 5'd5};
        src_rf_val_in = {32'h1234, 32'h9999};
        cdb_valid_in           = 2'b01;
        cdb_id_in[IDX_W-1:0]   = 5'd5;
        cdb_value_in[XLEN-1:0] = 32'hDEAD;
        @(negedge clk_in);
        checks++; if (src_dep_out[IDX_W-1:0] !== 5'd0 || src_val_out[XLEN-1:0] !== 32'hDEAD) begin
            errors++; $display("FAIL src_cdb_bypass: got dep=%0h val=%0h want 0/dead", src_dep_out[IDX_W-1:0], src_val_out[XLEN-1:0]);
        end
        checks++; if (src_dep_out[2*IDX_W-1:IDX_W] !== 5'd4) begin errors++; $display("FAIL src_pending: got %0h want 4", src_dep_out[2*IDX_W-1:IDX_W]); end
        step();
        cdb_valid_in = 2'b11;
        cdb_id_in    = {5'd4, 5'd4};
        cdb_value_in = {32'h2222, 32'h1111};
        step();
        cdb_valid_in = '0;
        disp(T_LUI, 32'h14, 5'd7, 32'h5000, 32'h0, 1'b0);
        src_tag_in = {5'd6, 5'd4};
        @(negedge clk_in);
        checks++; if (src_dep_out[IDX_W-1:0] !== 5'd0 || src_val_out[XLEN-1:0] !== 32'h2222) begin
            errors++; $display("FAIL src_two_port: got dep=%0h val=%0h want 0/2222", src_dep_out[IDX_W-1:0], src_val_out[XLEN-1:0]);
        end
        checks++; if (src_dep_out[2*IDX_W-1:IDX_W] !== 5'd0 || src_val_out[2*XLEN-1:XLEN] !== 32'h5000) begin
            errors++; $display("FAIL src_lui_done: got dep=%0h val=%0h want 0/5000", src_dep_out[2*IDX_W-1:IDX_W], src_val_out[2*XLEN-1:XLEN]);
        end
        src_tag_in = {5'd3, 5'd0};
        #1;
        checks++; if (src_dep_out[IDX_W-1:0] !== 5'd0 || src_val_out[XLEN-1:0] !== 32'h9999 || src_dep_out[2*IDX_W-1:IDX_W] !== 5'd3) begin
            errors++; $display("FAIL src_tag0_rf: got dep1=%0h val1=%0h dep2=%0h want 0/9999/3", src_dep_out[IDX_W-1:0], src_val_out[XLEN-1:0], src_dep_out[2*IDX_W-1:IDX_W]);
        end
        step();
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        rdy_in = 1'b0;
        disp(T_ADDI, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0);
        rdy_in = 1'b1;
        checks++; if (tail_id_out !== 5'd1 || dut.count_q !== 5'd0) begin
            errors++; $display("FAIL rdy_freeze: got tail=%0h count=%0h want 1/0", tail_id_out, dut.count_q);
        end
    endtask

`ifdef ROB_PERF_CNT_EN
    task automatic test_perf();
        logic [IDX_W-1:0] br_id;
        do_reset();
        for (int i = 0; i < 9; i++) disp(T_LUI, XLEN'(4 * i), 5'd1, XLEN'(i), 32'h0, 1'b0);
        br_id = tail_id_out;
        disp(T_BRANCH, 32'h80, 5'd0, 32'h0, 32'h8, 1'b0);
        cdb0(br_id, 32'h1);
        step();
        step();
        checks++; if (perf_commit_cnt_out !== 32'd10 || perf_flush_cnt_out !== 32'd1) begin
            errors++; $display("FAIL perf_counts: got commits=%0d flushes=%0d want 10/1", perf_commit_cnt_out, perf_flush_cnt_out);
        end
    endtask
`endif

    initial begin
        rst_n_in = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        step();
        test_reset();
        test_in_order();
        test_full();
        test_store_ready();
        test_branch();
        test_jalr();
        test_src_lookup();
        test_rdy_freeze();
`ifdef ROB_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
